// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states,
// requester ids, and the read-data zero-extension helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LDR  = 1'b1;

    // The memory returns lane data right-aligned; bits above the access size are junk.
    function automatic logic [31:0] zext_rdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {24'b0, data[7:0]};
            SZ_HALF: res = {16'b0, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational size / alignment / range checker for a byte-addressed access.
module dmem_align_chk
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic        err
);

    always_comb begin
        err = 1'b0;
        case (size)
            SZ_NONE: err = 1'b1;
            SZ_HALF: err = addr[0];
            SZ_WORD: err = (addr[1:0] != 2'b00);
            default: err = 1'b0;
        endcase
        if (addr[31:ADDR_W] != '0) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has priority, loader is forced through
// after STARVE_MAX consecutive core wins. One access per three cycles.
// Handshake: a requester holds req and its fields stable until gnt pulses; gnt is
// combinational in IDLE, the memory strobe follows one cycle later, and the winner
// sees exactly one rvalid pulse (with err/rdata) two cycles after gnt.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic              c_err,
    output logic [31:0]       c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [1:0]        l_size,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic              l_err,
    output logic [31:0]       l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state;
    state_e      state_nxt;
    logic [3:0]  starve_cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_id;
    logic        any_req;
    logic        pick_ldr;
    logic        chk_err;
    logic [31:0] resp_data;

    assign any_req  = c_req | l_req;
    assign pick_ldr = l_req & (~c_req | (starve_cnt == STARVE_LIM));

    dmem_align_chk #(.ADDR_W(ADDR_W)) u_chk (
        .size (lat_size),
        .addr (lat_addr),
        .err  (chk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request latch and starvation counter only move in IDLE, where arbitration happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_id     <= REQ_CORE;
        end else if (state == ST_IDLE) begin
            if (any_req) begin
                lat_id    <= pick_ldr ? REQ_LDR : REQ_CORE;
                lat_we    <= pick_ldr ? l_we    : c_we;
                lat_size  <= pick_ldr ? l_size  : c_size;
                lat_addr  <= pick_ldr ? l_addr  : c_addr;
                lat_wdata <= pick_ldr ? l_wdata : c_wdata;
            end
            if (!l_req || pick_ldr) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        l_rvalid  = 1'b0;
        c_err     = 1'b0;
        l_err     = 1'b0;
        c_rdata   = '0;
        l_rdata   = '0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        resp_data = '0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                c_gnt = any_req & ~pick_ldr;
                l_gnt = any_req & pick_ldr;
            end
            ST_ACCESS: begin
                m_en = ~chk_err;
                m_we = ~chk_err & lat_we;
            end
            ST_RESP: begin
                if (!chk_err && !lat_we) begin
                    resp_data = zext_rdata(lat_size, m_rdata);
                end
                if (lat_id == REQ_LDR) begin
                    l_rvalid = 1'b1;
                    l_err    = chk_err;
                    l_rdata  = resp_data;
                end else begin
                    c_rvalid = 1'b1;
                    c_err    = chk_err;
                    c_rdata  = resp_data;
                end
            end
            default: ;
        endcase
    end

    assign m_size    = lat_size;
    assign m_addr    = lat_addr[ADDR_W-1:0];
    assign m_wdata   = lat_wdata;
    assign fsm_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory behind the port, a reference byte
// array plus arbitration model, directed scenarios and a randomized mixed run.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 11;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c_req = 0, c_we = 0, l_req = 0, l_we = 0;
    logic [1:0]  c_size = 0, l_size = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, l_addr = 0, l_wdata = 0;
    logic c_gnt, c_rvalid, c_err, l_gnt, l_rvalid, l_err;
    logic [31:0] c_rdata, l_rdata;
    logic m_en, m_we, busy;
    logic [1:0] m_size, fsm_state;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 0;

    int total = 0;
    int bad = 0;

    logic [7:0] mem     [0:2047];
    logic [7:0] ref_mem [0:2047];
    logic       mem_fill = 1'b1;

    tx_t c_tx, l_tx;
    int          obs_wait;
    logic        obs_timeout, obs_both, obs_gnt_c, obs_gnt_l;
    logic        obs_men, obs_mwe, obs_busy_t1, obs_rv_t1, obs_gnt_t1;
    logic [ADDR_W-1:0] obs_maddr;
    logic [1:0]  obs_msize;
    logic [31:0] obs_mwdata;
    logic        obs_rv_c, obs_rv_l, obs_err, obs_men_t2, obs_busy_t2;
    logic [31:0] obs_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_size(l_size), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory behind the port ----------------
    function automatic logic [7:0] fill_byte(input int i);
        return 8'((i * 151 + 77) ^ (i >> 4));
    endfunction

    wire [ADDR_W-1:0] ma1 = m_addr + 11'd1;
    wire [ADDR_W-1:0] ma2 = m_addr + 11'd2;
    wire [ADDR_W-1:0] ma3 = m_addr + 11'd3;

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 2048; i++) mem[i] <= fill_byte(i);
        end else if (m_en) begin
            if (m_we) begin
                mem[m_addr] <= m_wdata[7:0];
                if (m_size != 2'b01) mem[ma1] <= m_wdata[15:8];
                if (m_size == 2'b11) begin
                    mem[ma2] <= m_wdata[23:16];
                    mem[ma3] <= m_wdata[31:24];
                end
            end else begin
                m_rdata <= {mem[ma3], mem[ma2], mem[ma1], mem[m_addr]};
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b00) || (size == 2'b10 && addr[0]) ||
               (size == 2'b11 && addr[1:0] != 2'b00) || (addr >= 32'd2048);
    endfunction

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < size_bytes(size); i++) v[8*i +: 8] = ref_mem[addr[10:0] + 11'(i)];
        return v;
    endfunction

    task automatic model_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < size_bytes(size); i++) ref_mem[addr[10:0] + 11'(i)] = data[8*i +: 8];
    endtask

    function automatic logic [31:0] expect_rdata(input tx_t t);
        return (t.we || model_err(t.size, t.addr)) ? 32'd0 : model_read(t.size, t.addr);
    endfunction

    function automatic tx_t mk_tx(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        tx_t t;
        t.we = we; t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic tx_t rand_tx();
        tx_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.size  = ($urandom_range(0, 99) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
        t.addr  = 32'($urandom_range(0, 2047));
        t.wdata = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            if (t.size == 2'b10) t.addr[0] = 1'b0;
            if (t.size == 2'b11) t.addr[1:0] = 2'b00;
        end
        if ($urandom_range(0, 19) == 0) t.addr[12] = 1'b1;
        return t;
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge with the DUT in IDLE; leaves the same way.
    task automatic drive_round(input logic c_on, input logic l_on);
        int waited;
        c_req = c_on; c_we = c_tx.we; c_size = c_tx.size; c_addr = c_tx.addr; c_wdata = c_tx.wdata;
        l_req = l_on; l_we = l_tx.we; l_size = l_tx.size; l_addr = l_tx.addr; l_wdata = l_tx.wdata;
        obs_timeout = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!c_gnt && !l_gnt && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        obs_wait = waited;
        if (!c_gnt && !l_gnt) begin
            obs_timeout = 1'b1;
            c_req = 1'b0;
            l_req = 1'b0;
            @(posedge clk); #1;
            return;
        end
        obs_gnt_c = c_gnt;
        obs_gnt_l = l_gnt;
        obs_both  = c_gnt & l_gnt;
        @(posedge clk); #1;
        if (obs_gnt_c) c_req = 1'b0;
        else l_req = 1'b0;
        @(negedge clk);
        obs_men = m_en; obs_mwe = m_we; obs_maddr = m_addr; obs_msize = m_size; obs_mwdata = m_wdata;
        obs_busy_t1 = busy; obs_rv_t1 = c_rvalid | l_rvalid; obs_gnt_t1 = c_gnt | l_gnt;
        @(negedge clk);
        obs_rv_c = c_rvalid; obs_rv_l = l_rvalid;
        obs_rdata = obs_gnt_c ? c_rdata : l_rdata;
        obs_err   = obs_gnt_c ? c_err : l_err;
        obs_men_t2 = m_en; obs_busy_t2 = busy;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, m_en, m_we, busy} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b exp 000000000",
                     {c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, m_en, m_we, busy});
        end
        total++;
        if ({c_rdata, l_rdata} !== 64'd0) begin
            bad++;
            $display("FAIL reset_rdata: got %h exp 0", {c_rdata, l_rdata});
        end
        total++;
        if ({m_addr, m_size, m_wdata} !== 45'd0 || fsm_state !== 2'b00) begin
            bad++;
            $display("FAIL reset_mbus: got addr=%h size=%h wdata=%h st=%0d exp all 0",
                     m_addr, m_size, m_wdata, fsm_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_fill = 1'b0;
    endtask

    task automatic test_word_rw();
        tx_t seq [2];
        seq[0] = mk_tx(1'b1, 2'b11, 32'h010, 32'hDEADBEEF);
        seq[1] = mk_tx(1'b0, 2'b11, 32'h010, 32'h0);
        for (int i = 0; i < 2; i++) begin
            c_tx = seq[i];
            drive_round(1'b1, 1'b0);
            total++;
            if (obs_timeout || obs_wait != 0 || obs_gnt_c !== 1'b1 || obs_gnt_l !== 1'b0) begin
                bad++;
                $display("FAIL word_gnt[%0d]: got to=%b wait=%0d c=%b l=%b exp gnt_c at T",
                         i, obs_timeout, obs_wait, obs_gnt_c, obs_gnt_l);
            end
            total++;
            if ({obs_men, obs_mwe, obs_maddr, obs_msize} !== {1'b1, seq[i].we, 11'h010, 2'b11} ||
                (seq[i].we && obs_mwdata !== 32'hDEADBEEF)) begin
                bad++;
                $display("FAIL word_mbus[%0d]: got en=%b we=%b a=%h s=%h wd=%h exp en=1 we=%b a=010 s=3",
                         i, obs_men, obs_mwe, obs_maddr, obs_msize, obs_mwdata, seq[i].we);
            end
            total++;
            if ({obs_rv_t1, obs_gnt_t1, obs_busy_t1, obs_rv_c, obs_rv_l, obs_err, obs_men_t2, obs_busy_t2}
                !== 8'b00110001) begin
                bad++;
                $display("FAIL word_timing[%0d]: got %b exp 00110001", i,
                         {obs_rv_t1, obs_gnt_t1, obs_busy_t1, obs_rv_c, obs_rv_l, obs_err, obs_men_t2, obs_busy_t2});
            end
            total++;
            if (obs_rdata !== (seq[i].we ? 32'h0 : 32'hDEADBEEF)) begin
                bad++;
                $display("FAIL word_rdata[%0d]: got %h exp %h", i, obs_rdata, seq[i].we ? 32'h0 : 32'hDEADBEEF);
            end
            if (seq[i].we) model_write(seq[i].size, seq[i].addr, seq[i].wdata);
        end
    endtask

    task automatic test_sub_word();
        tx_t         seq [5];
        logic [31:0] exp [5];
        seq[0] = mk_tx(1'b1, 2'b01, 32'h013, 32'hFFFF_FFA5); exp[0] = 32'h0;
        seq[1] = mk_tx(1'b1, 2'b01, 32'h012, 32'h1234_56EF); exp[1] = 32'h0;
        seq[2] = mk_tx(1'b0, 2'b10, 32'h012, 32'h0);         exp[2] = 32'h0000A5EF;
        seq[3] = mk_tx(1'b0, 2'b01, 32'h013, 32'h0);         exp[3] = 32'h000000A5;
        seq[4] = mk_tx(1'b0, 2'b11, 32'h010, 32'h0);         exp[4] = 32'hA5EFBEEF;
        for (int i = 0; i < 5; i++) begin
            c_tx = seq[i];
            drive_round(1'b1, 1'b0);
            total++;
            if (obs_timeout || {obs_men, obs_rv_c, obs_err} !== 3'b110 || obs_rdata !== exp[i]) begin
                bad++;
                $display("FAIL sub_word[%0d]: got to=%b en=%b rv=%b err=%b rdata=%h exp en=1 rv=1 err=0 rdata=%h",
                         i, obs_timeout, obs_men, obs_rv_c, obs_err, obs_rdata, exp[i]);
            end
            if (seq[i].we) model_write(seq[i].size, seq[i].addr, seq[i].wdata);
        end
    endtask

    task automatic test_errors();
        tx_t seq [5];
        seq[0] = mk_tx(1'b0, 2'b11, 32'h006, 32'h0);
        seq[1] = mk_tx(1'b0, 2'b10, 32'h001, 32'h0);
        seq[2] = mk_tx(1'b0, 2'b00, 32'h010, 32'h0);
        seq[3] = mk_tx(1'b0, 2'b11, 32'h800, 32'h0);
        seq[4] = mk_tx(1'b1, 2'b11, 32'h012, 32'h5555_5555);
        for (int i = 0; i < 5; i++) begin
            c_tx = seq[i];
            drive_round(1'b1, 1'b0);
            total++;
            if (obs_timeout || {obs_men, obs_mwe, obs_men_t2} !== 3'b000) begin
                bad++;
                $display("FAIL err_no_strobe[%0d]: got to=%b en=%b we=%b exp no strobe",
                         i, obs_timeout, obs_men, obs_mwe);
            end
            total++;
            if ({obs_rv_c, obs_rv_l, obs_err} !== 3'b101 || obs_rdata !== 32'h0) begin
                bad++;
                $display("FAIL err_resp[%0d]: got rv_c=%b rv_l=%b err=%b rdata=%h exp 1 0 1 0",
                         i, obs_rv_c, obs_rv_l, obs_err, obs_rdata);
            end
        end
        c_tx = mk_tx(1'b0, 2'b11, 32'h010, 32'h0);
        drive_round(1'b1, 1'b0);
        total++;
        if (obs_rdata !== 32'hA5EFBEEF) begin
            bad++;
            $display("FAIL err_write_blocked: got %h exp a5efbeef", obs_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_l;
        c_tx = mk_tx(1'b0, 2'b11, 32'h010, 32'h0);
        l_tx = mk_tx(1'b0, 2'b11, 32'h020, 32'h0);
        for (int i = 0; i < 10; i++) begin
            exp_l = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
            drive_round(1'b1, 1'b1);
            total++;
            if (obs_timeout || obs_both || obs_wait != 0 || {obs_gnt_c, obs_gnt_l} !== {~exp_l, exp_l}) begin
                bad++;
                $display("FAIL starve_order[%0d]: got to=%b both=%b wait=%0d c=%b l=%b exp c=%b l=%b",
                         i, obs_timeout, obs_both, obs_wait, obs_gnt_c, obs_gnt_l, ~exp_l, exp_l);
            end
            total++;
            if ({obs_rv_c, obs_rv_l} !== {~exp_l, exp_l} ||
                obs_rdata !== expect_rdata(exp_l ? l_tx : c_tx)) begin
                bad++;
                $display("FAIL starve_resp[%0d]: got rv_c=%b rv_l=%b rdata=%h exp rdata=%h",
                         i, obs_rv_c, obs_rv_l, obs_rdata, expect_rdata(exp_l ? l_tx : c_tx));
            end
        end
        c_req = 1'b0;
        l_req = 1'b0;
    endtask

    task automatic test_random_mixed();
        logic c_pend, l_pend, pred_l, e_err;
        int   starve;
        tx_t  t;
        c_pend = 1'b0;
        l_pend = 1'b0;
        starve = 0;
        @(posedge clk); #1;
        for (int r = 0; r < 60; r++) begin
            if (!c_pend && $urandom_range(0, 1) == 1) begin c_tx = rand_tx(); c_pend = 1'b1; end
            if (!l_pend && $urandom_range(0, 1) == 1) begin l_tx = rand_tx(); l_pend = 1'b1; end
            if (!c_pend && !l_pend) begin c_tx = rand_tx(); c_pend = 1'b1; end
            pred_l = l_pend && (!c_pend || starve == STARVE_MAX);
            t      = pred_l ? l_tx : c_tx;
            e_err  = model_err(t.size, t.addr);
            drive_round(c_pend, l_pend);
            total++;
            if (obs_timeout || obs_both || {obs_gnt_c, obs_gnt_l} !== {~pred_l, pred_l}) begin
                bad++;
                $display("FAIL rand_winner[%0d]: got to=%b c=%b l=%b exp c=%b l=%b",
                         r, obs_timeout, obs_gnt_c, obs_gnt_l, ~pred_l, pred_l);
            end
            total++;
            if (obs_men !== ~e_err ||
                (!e_err && {obs_mwe, obs_maddr, obs_msize, obs_mwdata} !== {t.we, t.addr[10:0], t.size, t.wdata})) begin
                bad++;
                $display("FAIL rand_mbus[%0d]: got en=%b we=%b a=%h s=%h wd=%h exp en=%b we=%b a=%h s=%h wd=%h",
                         r, obs_men, obs_mwe, obs_maddr, obs_msize, obs_mwdata,
                         ~e_err, t.we, t.addr[10:0], t.size, t.wdata);
            end
            total++;
            if ({obs_rv_c, obs_rv_l, obs_err} !== {~pred_l, pred_l, e_err} || obs_rdata !== expect_rdata(t)) begin
                bad++;
                $display("FAIL rand_resp[%0d]: got rv_c=%b rv_l=%b err=%b rdata=%h exp err=%b rdata=%h",
                         r, obs_rv_c, obs_rv_l, obs_err, obs_rdata, e_err, expect_rdata(t));
            end
            if (!e_err && t.we) model_write(t.size, t.addr, t.wdata);
            if (l_pend && !pred_l) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
            else starve = 0;
            if (pred_l) l_pend = 1'b0;
            else c_pend = 1'b0;
        end
        c_req = 1'b0;
        l_req = 1'b0;
    endtask

    task automatic test_reset_in_access();
        c_tx = mk_tx(1'b0, 2'b11, 32'h010, 32'h0);
        c_req = 1'b1; c_we = c_tx.we; c_size = c_tx.size; c_addr = c_tx.addr; c_wdata = c_tx.wdata;
        @(negedge clk);
        total++;
        if (c_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rst_acc_gnt: got %b exp 1", c_gnt);
        end
        @(posedge clk); #1;
        c_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({m_en, m_we, busy} !== 3'b101) begin
            bad++;
            $display("FAIL rst_acc_strobe: got %b exp 101", {m_en, m_we, busy});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({c_rvalid, l_rvalid, busy, m_en, fsm_state} !== 5'b0 || {c_rdata, m_addr} !== 43'd0) begin
            bad++;
            $display("FAIL rst_acc_after: got rv=%b%b busy=%b en=%b st=%0d rdata=%h addr=%h exp all 0",
                     c_rvalid, l_rvalid, busy, m_en, fsm_state, c_rdata, m_addr);
        end
        @(posedge clk); #1;
        drive_round(1'b1, 1'b0);
        total++;
        if (obs_timeout || {obs_gnt_c, obs_rv_c, obs_err} !== 3'b110 || obs_rdata !== expect_rdata(c_tx)) begin
            bad++;
            $display("FAIL rst_acc_resume: got to=%b gnt=%b rv=%b err=%b rdata=%h exp rdata=%h",
                     obs_timeout, obs_gnt_c, obs_rv_c, obs_err, obs_rdata, expect_rdata(c_tx));
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = fill_byte(i);
        c_tx = '0;
        l_tx = '0;
        test_reset();
        test_word_rw();
        test_sub_word();
        test_errors();
        test_starvation();
        test_random_mixed();
        test_reset_in_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port (byte-addressed, byte/half/word sized, 1-cycle synchronous read) between two requesters: the core load/store unit and the memory loader/debug port. Fixed core priority with a starvation limit for the loader, a per-access req/gnt/rvalid handshake, and alignment/range checking before the memory is touched. Sits between the memory stage and the data memory array.

## Interface
- ADDR_W, 11, memory byte-address width (2048 bytes)
- STARVE_MAX, 4, consecutive core wins while the loader waits before the loader is forced to win (1..15)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- c_req, c_we  in  1  core request / write enable
- c_size  in  2  01 byte, 10 half, 11 word, 00 invalid
- c_addr, c_wdata  in  32  core byte address / write data (right-aligned)
- c_gnt, c_rvalid, c_err  out  1  grant pulse / response pulse / error flag (valid with c_rvalid)
- c_rdata  out  32  read data, zero-extended, valid with c_rvalid
- l_req, l_we, l_size, l_addr, l_wdata, l_gnt, l_rvalid, l_err, l_rdata: loader port, identical widths and meaning
- m_en, m_we  out  1  memory access strobe / write enable
- m_size  out  2  access size, same encoding
- m_addr  out  ADDR_W  memory byte address
- m_wdata  out  32  write data
- m_rdata  in  32  read data, valid the cycle after m_en && !m_we
- busy  out  1  high whenever state != IDLE

## Operation
- FSM: IDLE, ACCESS, RESP.
- IDLE: if any req, choose winner, pulse its gnt combinationally this cycle, latch we/size/addr/wdata and winner id, go ACCESS. Requester holds req and fields stable until gnt.
- Winner: core if c_req, unless l_req && starve_cnt == STARVE_MAX, then loader. Loader alone → loader.
- starve_cnt: +1 when core granted while l_req high; cleared on loader grant or when l_req low in IDLE; saturates at STARVE_MAX.
- Check (on latched fields): err if size == 00, half with addr[0] != 0, word with addr[1:0] != 0, or addr[31:ADDR_W] != 0.
- ACCESS: no err → m_en=1, m_we/m_size/m_addr/m_wdata from latch; err → m_en=0. Go RESP.
- RESP: pulse winner's rvalid for one cycle; err=latched check; rdata = zero-extended m_rdata (byte: [7:0], half: [15:0], word: all) for reads, 0 for writes and errors. Go IDLE.
- Non-winner's gnt/rvalid stay 0; its request waits in IDLE.
- Outside ACCESS, m_en=m_we=0; m_addr/m_size/m_wdata hold latched values.

## Timing
- Reset: state IDLE, starve_cnt 0, latches 0; all gnt, rvalid, err, m_en, m_we, busy = 0; rdata and m_* buses = 0.
- Latency: gnt in cycle T (IDLE), m_en in T+1, rvalid in T+2. One access per 3 cycles; next gnt no earlier than T+3.
- Write is committed in T+1; rvalid at T+2 is the write acknowledge.
- Simultaneous requests: resolved as above in the same IDLE cycle; exactly one gnt.
- req dropped before gnt: no access, no response.
- rst during ACCESS or RESP: access abandoned, no rvalid; a write strobed in the same cycle as rst is not guaranteed to commit.
- No combinational path from m_rdata to any output except c_rdata/l_rdata in RESP.

## Structure
- Package dmem_pkg: size enum (SZ_NONE=00, SZ_BYTE=01, SZ_HALF=10, SZ_WORD=11), FSM state enum, requester-id constants (REQ_CORE=0, REQ_LDR=1).
- Sub-module dmem_align_chk: combinational size/alignment/range checker, parameter ADDR_W, inputs size+addr, output err. Reused by future cache/MMIO decode.

## Test plan
- Core word write 0xDEADBEEF @0x010, then word read @0x010 → gnt T, m_en T+1, c_rvalid T+2 with c_rdata=0xDEADBEEF, c_err=0.
- Byte write 0xA5 @0x013, half read @0x012 → c_rdata=0x0000A5EF; byte read @0x013 → 0x000000A5.
- Misaligned word @0x006, half @0x001, size 00, addr 0x800 → m_en never high, rvalid T+2 with err=1, rdata=0.
- c_req and l_req held high continuously, STARVE_MAX=4 → grant order C,C,C,C,L,C,C,C,C,L; never two gnt in one cycle.
- rst asserted in ACCESS of a read → no rvalid, outputs at reset values next cycle, busy=0; new request after release granted normally.
